// File: rtl/cnn_pkg.sv
// Shared CNN-stage definitions: default geometry, window padding,
// derived output grid size and the window-generator state encodings.
// WIN_ZERO_PAD_EN selects zero padding of (K-1)/2 around the image.
package cnn_pkg;

    localparam int DATA_W = 16;
    localparam int IMG_W  = 30;
    localparam int IMG_H  = 30;
    localparam int K      = 3;

    // Border added on each side of the image before windowing.
    function automatic int pad_of(input int k);
`ifdef WIN_ZERO_PAD_EN
        return (k - 1) / 2;
`else
        return 0;
`endif
    endfunction

    // Number of window origins along one image dimension.
    function automatic int out_dim(input int img, input int k);
        return img - k + 1 + 2 * pad_of(k);
    endfunction

    localparam int OUT_W = out_dim(IMG_W, K);
    localparam int OUT_H = out_dim(IMG_H, K);

    // Window generator states.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;
    localparam logic [1:0] ST_FIN  = 2'd3;

endpackage

// File: rtl/win_pos_cnt.sv
// Raster counter for window origins: col steps first, wraps to 0 at the
// last column and row then steps. Provides the next position so the
// caller can register the following window on the same edge.
module win_pos_cnt
    import cnn_pkg::*;
#(
    parameter int GRID_W = cnn_pkg::OUT_W,
    parameter int GRID_H = cnn_pkg::OUT_H
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       advance,
    output logic [7:0] row,
    output logic [7:0] col,
    output logic [7:0] nxt_row,
    output logic [7:0] nxt_col,
    output logic       last
);

    localparam logic [7:0] LAST_COL = 8'(GRID_W - 1);
    localparam logic [7:0] LAST_ROW = 8'(GRID_H - 1);

    // Next raster position and last-origin flag.
    always_comb begin
        nxt_row = row;
        nxt_col = col + 8'd1;
        last    = (row == LAST_ROW) && (col == LAST_COL);
        if (col == LAST_COL) begin
            nxt_col = 8'd0;
            nxt_row = (row == LAST_ROW) ? 8'd0 : row + 8'd1;
        end
    end

    // Position register: cleared at frame load, stepped per accepted window.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row <= 8'd0;
            col <= 8'd0;
        end else if (clear) begin
            row <= 8'd0;
            col <= 8'd0;
        end else if (advance) begin
            row <= nxt_row;
            col <= nxt_col;
        end
    end

endmodule

// File: rtl/img_window_gen.sv
// Sliding KxK window generator over a flat image held in a register.
// Optional macro WIN_ZERO_PAD_EN: zero padding of (K-1)/2 around the image.
//
// Output handshake: a window transfers on a rising edge where win_valid
// and win_ready are both 1. While win_valid=1 the window, row_idx and
// col_idx hold until that transfer; win_valid never drops without one
// (except reset). win_ready has no effect while win_valid=0.
module img_window_gen #(
    parameter int DATA_W = cnn_pkg::DATA_W,
    parameter int IMG_W  = cnn_pkg::IMG_W,
    parameter int IMG_H  = cnn_pkg::IMG_H,
    parameter int K      = cnn_pkg::K
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start_flag,
    input  logic [IMG_W*IMG_H*DATA_W-1:0] img_data,
    output logic [K*K*DATA_W-1:0]         win_data,
    output logic                          win_valid,
    input  logic                          win_ready,
    output logic [7:0]                    row_idx,
    output logic [7:0]                    col_idx,
    output logic                          busy,
    output logic                          done,
    output logic [1:0]                    state_dbg
);
    import cnn_pkg::*;

    localparam int WIN_PAD = pad_of(K);
    localparam int GRID_W  = out_dim(IMG_W, K);
    localparam int GRID_H  = out_dim(IMG_H, K);

    logic [1:0]                    state;
    logic [IMG_W*IMG_H*DATA_W-1:0] img_reg;
    logic [K*K*DATA_W-1:0]         win_nxt;
    logic [7:0]                    nxt_row;
    logic [7:0]                    nxt_col;
    logic [7:0]                    src_row;
    logic [7:0]                    src_col;
    logic                          pos_last;
    logic                          hs;

    assign hs        = win_valid & win_ready;
    assign busy      = (state != ST_IDLE);
    assign state_dbg = state;

    win_pos_cnt #(
        .GRID_W (GRID_W),
        .GRID_H (GRID_H)
    ) u_pos (
        .clk     (clk),
        .rst     (rst),
        .clear   (state == ST_LOAD),
        .advance (hs && !pos_last),
        .row     (row_idx),
        .col     (col_idx),
        .nxt_row (nxt_row),
        .nxt_col (nxt_col),
        .last    (pos_last)
    );

    // Image capture one cycle after start; deliberately not reset.
    always_ff @(posedge clk) begin
        if (state == ST_LOAD) img_reg <= img_data;
    end

    // Pixel fetch relative to the padded image; outside reads as zero.
    function automatic logic [DATA_W-1:0] pixel_at(input int r, input int c);
`ifdef WIN_ZERO_PAD_EN
        if (r < 0 || r >= IMG_H || c < 0 || c >= IMG_W) return '0;
`endif
        return img_reg[(r * IMG_W + c) * DATA_W +: DATA_W];
    endfunction

    // Window to register next: the following origin on a transfer,
    // otherwise the current origin (first window of a frame).
    always_comb begin
        src_row = hs ? nxt_row : row_idx;
        src_col = hs ? nxt_col : col_idx;
        win_nxt = '0;
        for (int i = 0; i < K; i++) begin
            for (int j = 0; j < K; j++) begin
                win_nxt[(i * K + j) * DATA_W +: DATA_W] =
                    pixel_at(int'(src_row) + i - WIN_PAD, int'(src_col) + j - WIN_PAD);
            end
        end
    end

    // Control FSM and registered window output.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            win_valid <= 1'b0;
            win_data  <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: if (start_flag) state <= ST_LOAD;
                ST_LOAD: state <= ST_RUN;
                ST_RUN: begin
                    if (!win_valid) begin
                        win_data  <= win_nxt;
                        win_valid <= 1'b1;
                    end else if (win_ready) begin
                        if (pos_last) begin
                            win_valid <= 1'b0;
                            done      <= 1'b1;
                            state     <= ST_FIN;
                        end else begin
                            win_data <= win_nxt;
                        end
                    end
                end
                ST_FIN:  state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/img_window_gen.md
IMG_WINDOW_GEN -- requirements
Module: img_window_gen

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16: pixel width in bits.
REQ-002 The block SHALL have parameter IMG_W, default 30: image width in pixels.
REQ-003 The block SHALL have parameter IMG_H, default 30: image height in pixels.
REQ-004 The block SHALL have parameter K, default 3: square window side.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port start_flag, input, 1 bit: start request, sampled in IDLE only.
REQ-008 The block SHALL have port img_data, input, IMG_W*IMG_H*DATA_W bits: flat image; pixel p=r*IMG_W+c sits at [p*DATA_W +: DATA_W].
REQ-009 The block SHALL have port win_data, output, K*K*DATA_W bits: window; element (i,j) sits at [(i*K+j)*DATA_W +: DATA_W].
REQ-010 The block SHALL have port win_valid, output, 1 bit: win_data is valid.
REQ-011 The block SHALL have port win_ready, input, 1 bit: the consumer accepts the window.
REQ-012 The block SHALL have ports row_idx and col_idx, output, 8 bits each: origin of the current window.
REQ-013 The block SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-014 The block SHALL have port done, output, 1 bit: one-cycle pulse after the last window is accepted.

Function
REQ-015 The state machine SHALL have four states: IDLE, LOAD, RUN, FIN.
- IDLE -> LOAD on start_flag=1.
- LOAD -> RUN after one cycle.
- RUN -> FIN on the last handshake.
- FIN -> IDLE after one cycle.
REQ-016 In LOAD, the block SHALL capture img_data into an internal image register. This absorbs the one-cycle latency of the upstream ROM.
REQ-017 Timing from start SHALL be: edge E0 samples start_flag; E1 captures the image; E2 registers the first window (origin 0,0) with win_valid=1.
REQ-018 A handshake SHALL be win_valid=1 and win_ready=1 on a rising edge.
REQ-019 While win_valid=1 and win_ready=0, win_data, row_idx and col_idx SHALL hold stable.
REQ-020 On a handshake that is not the last, the next window SHALL be registered on the same edge, so there are no bubbles: one window per cycle while win_ready=1.
REQ-021 Windows SHALL be emitted in raster order: col_idx increments; it wraps to 0 after the last column, and row_idx then increments.
REQ-022 Without padding, the output grid SHALL be OUT = IMG_W-K+1 wide and IMG_H-K+1 high (28x28, 784 windows). Element (i,j) SHALL be pixel (row_idx+i, col_idx+j).
REQ-023 On the last handshake, win_valid SHALL clear on that same edge. done SHALL be 1 for exactly the following cycle (FIN).
REQ-024 start_flag SHALL be ignored in LOAD, RUN and FIN. A new image is loaded only from IDLE.
REQ-025 win_ready asserted while win_valid=0 SHALL have no effect.

Reset
REQ-026 While rst=0, the block SHALL asynchronously force the following, and the image register is not cleared:
- state = IDLE
- win_valid = 0, busy = 0, done = 0
- win_data = 0, row_idx = 0, col_idx = 0
REQ-027 Reset asserted mid-RUN SHALL abort the frame with no done pulse. The next start_flag SHALL restart from window (0,0).

Configuration
REQ-028 With macro WIN_ZERO_PAD_EN defined, the block SHALL use zero padding of (K-1)/2.
- Output grid is IMG_W x IMG_H (900 windows).
- Element (i,j) is pixel (row_idx+i-1, col_idx+j-1); out-of-range pixels read as 0.
REQ-029 Without WIN_ZERO_PAD_EN, the block SHALL behave per REQ-022, with no padding logic synthesized.

Structure
REQ-030 A shared package/include cnn_pkg SHALL hold the following, reused by the other CNN stages:
- DATA_W, IMG_W, IMG_H, K
- derived OUT_W and OUT_H (conditional on WIN_ZERO_PAD_EN)
- state encodings
REQ-031 One sub-module, win_pos_cnt, SHALL hold the row/col raster counter with wrap and a last-position flag. Window extraction SHALL stay in img_window_gen.

Verification
REQ-032 Ramp test: img_data pixel p=p, win_ready=1, start pulse -> win_valid rises 2 edges after start. The first window is {0,1,2,30,31,32,60,61,62}. Exactly 784 valid cycles follow, then one done pulse.
REQ-033 Last window: same ramp -> the final window has origin (27,27) and data {837,838,839,867,868,869,897,898,899}.
REQ-034 Backpressure: win_ready toggles 1,0,0,1 -> data and indices stay frozen during the 0 cycles. No window is skipped or duplicated; all 784 windows are recorded against the model.
REQ-035 Reset mid-frame: rst=0 at window 100 -> all outputs 0 immediately and no done. A restart yields window (0,0) = {0,1,2,30,...}.
REQ-036 Start while busy: start_flag=1 during RUN, with img_data changed to all 0xFFFF -> the window stream still shows ramp values and there is a single done.
REQ-037 With WIN_ZERO_PAD_EN and the ramp image -> the first window is {0,0,0,0,0,1,0,30,31}. There are 900 windows; the last is {868,869,0,898,899,0,0,0,0}.
